// File: rtl/mouse_vga_pkg.sv
// mouse_vga_pkg: screen geometry, arrow pixel codes and cursor colours shared by the overlay
package mouse_vga_pkg;
    localparam int H_ACTIVE  = 640;
    localparam int V_ACTIVE  = 480;
    localparam int CURSOR_SZ = 8;
    localparam logic [1:0] CODE_TRANSP  = 2'b00;
    localparam logic [1:0] CODE_OUTLINE = 2'b01;
    localparam logic [1:0] CODE_FILL    = 2'b10;
    localparam logic [7:0] COL_LEFT    = 8'hE0;
    localparam logic [7:0] COL_RIGHT   = 8'h1C;
    localparam logic [7:0] COL_MIDDLE  = 8'h03;
    localparam logic [7:0] COL_IDLE    = 8'hFF;
    localparam logic [7:0] COL_OUTLINE = 8'h00;
endpackage

// File: rtl/cursor_rom.sv
// cursor_rom: combinational 8x8 arrow shape, row/col inside the cursor box -> pixel code
module cursor_rom (
    input  logic [2:0] row,
    input  logic [2:0] col,
    output logic [1:0] code
);
    import mouse_vga_pkg::*;
    always_comb code = (col == 3'd0 || col == row) ? CODE_OUTLINE : (col < row) ? CODE_FILL : CODE_TRANSP;
endmodule

// File: rtl/mouse_cursor_overlay.sv
// mouse_cursor_overlay: 2-stage pixel pipeline drawing an arrow cursor over RGB332 video; ports: CLK/RST, mouse position and buttons, VGA pixel/sync/colour in, composited colour and delayed syncs out
module mouse_cursor_overlay #(
    parameter int H_ACTIVE  = mouse_vga_pkg::H_ACTIVE,
    parameter int V_ACTIVE  = mouse_vga_pkg::V_ACTIVE,
    parameter int CURSOR_SZ = mouse_vga_pkg::CURSOR_SZ
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [9:0] XMouseVGA,
    input  logic [9:0] YMouseVGA,
    input  logic [2:0] Botones,
    input  logic [9:0] PixelX,
    input  logic [9:0] PixelY,
    input  logic       VideoOn,
    input  logic       HSyncIn,
    input  logic       VSyncIn,
    input  logic [7:0] RGBIn,
    output logic [7:0] RGBOut,
    output logic       HSyncOut,
    output logic       VSyncOut
);
    import mouse_vga_pkg::*;
    localparam logic [9:0] X_MAX = 10'(H_ACTIVE - CURSOR_SZ);
    localparam logic [9:0] Y_MAX = 10'(V_ACTIVE - CURSOR_SZ);
    localparam logic [9:0] SZ    = 10'(CURSOR_SZ);
    logic       vs_q, frame_ev, hit_c;
    logic [9:0] cur_x, cur_y, dx, dy;
    logic [2:0] cur_btn;
    logic [7:0] fill_c;
    logic       hit1, von1, hs1, vs1;
    logic [2:0] col1, row1;
    logic [7:0] rgb1, fill1;
    logic [1:0] code;
    always_comb begin
        frame_ev = vs_q & ~VSyncIn;
        dx       = PixelX - cur_x;
        dy       = PixelY - cur_y;
        hit_c    = (PixelX >= cur_x) && (dx < SZ) && (PixelY >= cur_y) && (dy < SZ);
        fill_c   = cur_btn[0] ? COL_LEFT : cur_btn[1] ? COL_RIGHT : cur_btn[2] ? COL_MIDDLE : COL_IDLE;
    end
    // shadow registers only move on a VSync fall so the cursor never tears mid-frame
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            vs_q    <= 1'b1;
            cur_x   <= 10'(H_ACTIVE / 2);
            cur_y   <= 10'(V_ACTIVE / 2);
            cur_btn <= '0;
        end else begin
            vs_q <= VSyncIn;
            if (frame_ev) begin
                cur_x   <= (XMouseVGA > X_MAX) ? X_MAX : XMouseVGA;
                cur_y   <= (YMouseVGA > Y_MAX) ? Y_MAX : YMouseVGA;
                cur_btn <= Botones;
            end
        end
    end
    // fill colour travels with the pixel so a capture between stages cannot recolour it
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            hit1  <= 1'b0;
            col1  <= '0;
            row1  <= '0;
            von1  <= 1'b0;
            hs1   <= 1'b1;
            vs1   <= 1'b1;
            rgb1  <= '0;
            fill1 <= '0;
        end else begin
            hit1  <= hit_c;
            col1  <= dx[2:0];
            row1  <= dy[2:0];
            von1  <= VideoOn;
            hs1   <= HSyncIn;
            vs1   <= VSyncIn;
            rgb1  <= RGBIn;
            fill1 <= fill_c;
        end
    end
    cursor_rom u_rom (
        .row  (row1),
        .col  (col1),
        .code (code)
    );
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            RGBOut   <= '0;
            HSyncOut <= 1'b1;
            VSyncOut <= 1'b1;
        end else begin
            RGBOut   <= !von1 ? 8'h00 : (hit1 && code != CODE_TRANSP) ? ((code == CODE_OUTLINE) ? COL_OUTLINE : fill1) : rgb1;
            HSyncOut <= hs1;
            VSyncOut <= vs1;
        end
    end
endmodule

// File: tb/tb_mouse_cursor_overlay.sv
// tb_mouse_cursor_overlay: directed scenarios with a scoreboard queue checked two cycles after each driven pixel
module tb_mouse_cursor_overlay;
    logic       CLK, RST;
    logic [9:0] XMouseVGA, YMouseVGA, PixelX, PixelY;
    logic [2:0] Botones;
    logic       VideoOn, HSyncIn, VSyncIn;
    logic [7:0] RGBIn, RGBOut;
    logic       HSyncOut, VSyncOut;

    typedef struct {
        string      tag;
        logic [7:0] rgb;
        logic       hs;
        logic       vs;
    } exp_t;
    exp_t q[$];

    int checks = 0;
    int errors = 0;
    int m_x = 320, m_y = 240;
    logic [2:0] m_btn = 3'b000;
    bit m_prev_vs = 1'b1;

    mouse_cursor_overlay dut (
        .CLK(CLK), .RST(RST), .XMouseVGA(XMouseVGA), .YMouseVGA(YMouseVGA), .Botones(Botones),
        .PixelX(PixelX), .PixelY(PixelY), .VideoOn(VideoOn), .HSyncIn(HSyncIn), .VSyncIn(VSyncIn),
        .RGBIn(RGBIn), .RGBOut(RGBOut), .HSyncOut(HSyncOut), .VSyncOut(VSyncOut)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [7:0] model_rgb(input int px, input int py, input bit von, input logic [7:0] rgb);
        int c, r;
        logic [7:0] fill;
        if (!von) return 8'h00;
        c = px - m_x;
        r = py - m_y;
        if (c < 0 || c >= 8 || r < 0 || r >= 8) return rgb;
        fill = m_btn[0] ? 8'hE0 : m_btn[1] ? 8'h1C : m_btn[2] ? 8'h03 : 8'hFF;
        if (c == 0 || c == r) return 8'h00;
        if (c < r) return fill;
        return rgb;
    endfunction

    task automatic check_out(input string tag, input logic [7:0] rgb, input logic hs, input logic vs);
        checks++;
        assert (RGBOut === rgb) else begin errors++; $error("FAIL %s RGBOut: got %h expected %h", tag, RGBOut, rgb); end
        checks++;
        assert (HSyncOut === hs) else begin errors++; $error("FAIL %s HSyncOut: got %b expected %b", tag, HSyncOut, hs); end
        checks++;
        assert (VSyncOut === vs) else begin errors++; $error("FAIL %s VSyncOut: got %b expected %b", tag, VSyncOut, vs); end
    endtask

    // exp < 0 means the expected colour comes from the reference model
    task automatic step(input string tag, input int px, input int py, input bit von, input bit hs, input bit vs,
                        input logic [7:0] rgb, input int exp = -1);
        exp_t e;
        @(negedge CLK);
        if (q.size() == 2) begin
            e = q.pop_front();
            check_out(e.tag, e.rgb, e.hs, e.vs);
        end
        PixelX  = 10'(px);
        PixelY  = 10'(py);
        VideoOn = von;
        HSyncIn = hs;
        VSyncIn = vs;
        RGBIn   = rgb;
        e.tag = tag;
        e.rgb = (exp >= 0) ? exp[7:0] : model_rgb(px, py, von, rgb);
        e.hs  = hs;
        e.vs  = vs;
        q.push_back(e);
        if (m_prev_vs && !vs) begin
            m_x   = (int'(XMouseVGA) > 632) ? 632 : int'(XMouseVGA);
            m_y   = (int'(YMouseVGA) > 472) ? 472 : int'(YMouseVGA);
            m_btn = Botones;
        end
        m_prev_vs = vs;
    endtask

    task automatic push_reset_pipe();
        exp_t e;
        q.delete();
        e.tag = "post_reset";
        e.rgb = 8'h00;
        e.hs  = 1'b1;
        e.vs  = 1'b1;
        q.push_back(e);
        q.push_back(e);
        m_x = 320; m_y = 240; m_btn = 3'b000; m_prev_vs = 1'b1;
    endtask

    initial begin
        RST = 1'b0; XMouseVGA = 10'd100; YMouseVGA = 10'd50; Botones = 3'b000;
        PixelX = '0; PixelY = '0; VideoOn = 1'b0; HSyncIn = 1'b1; VSyncIn = 1'b1; RGBIn = '0;
        repeat (3) @(negedge CLK);
        check_out("reset", 8'h00, 1'b1, 1'b1);
        RST = 1'b1;
        push_reset_pipe();

        step("home_outline", 320, 240, 1, 1, 1, 8'h55, 8'h00);
        step("home_fill",    323, 245, 1, 1, 1, 8'h55, 8'hFF);
        step("pre_event_bg", 100, 50,  1, 1, 1, 8'h55, 8'h55);

        step("s1_event",   0,   0,  0, 1, 0, 8'h55);
        step("s1_outline", 100, 50, 1, 1, 1, 8'h55, 8'h00);
        step("s1_fill",    103, 55, 1, 1, 1, 8'h55, 8'hFF);
        step("s1_transp",  105, 52, 1, 1, 1, 8'h55, 8'h55);
        step("s1_left",    99,  50, 1, 0, 1, 8'h55, 8'h55);
        step("s1_below",   100, 58, 1, 1, 1, 8'h55, 8'h55);

        XMouseVGA = 10'd700; YMouseVGA = 10'd479;
        step("s2_event",    0,   0,   0, 1, 0, 8'h55);
        step("s2_corner",   632, 472, 1, 1, 1, 8'h55, 8'h00);
        step("s2_outside",  631, 472, 1, 1, 1, 8'h55, 8'h55);
        step("s2_diag_end", 639, 479, 1, 1, 1, 8'h55, 8'h00);

        Botones = 3'b011;
        step("s3_ev_left",  0,   0,   0, 1, 0, 8'h55);
        step("s3_left",     635, 477, 1, 1, 1, 8'h55, 8'hE0);
        Botones = 3'b110;
        step("s3_ev_right", 0,   0,   0, 1, 0, 8'h55);
        step("s3_right",    635, 477, 1, 1, 1, 8'h55, 8'h1C);
        Botones = 3'b100;
        step("s3_ev_mid",   0,   0,   0, 1, 0, 8'h55);
        step("s3_mid",      635, 477, 1, 1, 1, 8'h55, 8'h03);

        XMouseVGA = 10'd100; YMouseVGA = 10'd50; Botones = 3'b000;
        step("s4_event",     0,   0,  0, 1, 0, 8'h55);
        step("s4_at100",     103, 55, 1, 1, 1, 8'h55, 8'hFF);
        XMouseVGA = 10'd200;
        step("s4_no_event",  103, 55, 1, 1, 1, 8'h55, 8'hFF);
        step("s4_not200",    203, 55, 1, 1, 1, 8'h55, 8'h55);
        step("s4_same_cyc",  103, 55, 1, 1, 0, 8'h55, 8'hFF);
        step("s4_moved_old", 103, 55, 1, 1, 1, 8'h55, 8'h55);
        step("s4_moved_new", 203, 55, 1, 1, 1, 8'h55, 8'hFF);

        step("s5_blank",  203, 55, 0, 1, 1, 8'h55, 8'h00);
        step("s5_tog0",   0,   0,  0, 0, 1, 8'h55);
        step("s5_tog1",   0,   0,  0, 1, 0, 8'h55);
        step("s5_tog2",   0,   0,  0, 0, 0, 8'h55);
        step("s5_tog3",   0,   0,  0, 1, 1, 8'h55);
        step("s5_tog4",   0,   0,  0, 0, 1, 8'h55);

        for (int i = 0; i < 16; i++)
            step("rand", m_x - 2 + int'($urandom_range(0, 11)), m_y - 2 + int'($urandom_range(0, 11)),
                 1, bit'($urandom_range(0, 1)), 1, 8'($urandom));

        step("s6_pre0", 203, 55, 1, 0, 1, 8'h55, 8'hFF);
        step("s6_pre1", 203, 55, 1, 0, 1, 8'h55, 8'hFF);
        step("s6_pre2", 203, 55, 1, 0, 1, 8'h55, 8'hFF);
        #2 RST = 1'b0;
        #1 check_out("s6_async_reset", 8'h00, 1'b1, 1'b1);
        VideoOn = 1'b0; HSyncIn = 1'b1; VSyncIn = 1'b1;
        XMouseVGA = 10'd500; YMouseVGA = 10'd100;
        repeat (2) @(negedge CLK);
        check_out("s6_held", 8'h00, 1'b1, 1'b1);
        RST = 1'b1;
        push_reset_pipe();
        step("s6_outline", 320, 240, 1, 1, 1, 8'h55, 8'h00);
        step("s6_fill",    323, 245, 1, 1, 1, 8'h55, 8'hFF);
        step("s6_no_move", 503, 105, 1, 1, 1, 8'h55, 8'h55);
        step("drain0", 0, 0, 0, 1, 1, 8'h00);
        step("drain1", 0, 0, 0, 1, 1, 8'h00);
        step("drain2", 0, 0, 0, 1, 1, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
